// File: rtl/udp_top_hls_deadlock_reporter.sv
// Deadlock reporter for udp_top: qualifies the monitor's block level over a
// persistence threshold and emits one frozen snapshot per deadlock episode.
module udp_top_hls_deadlock_reporter #(
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              block,
  input  logic [7:0]        axis_block_sigs,
  input  logic [17:0]       inst_idle_sigs,
  input  logic [10:0]       inst_block_sigs,
  output logic              report_valid,
  input  logic              report_ready,
  output logic [7:0]        report_axis,
  output logic [17:0]       report_idle,
  output logic [10:0]       report_chan,
  output logic [7:0]        report_seq,
  output logic              deadlock_active,
  output logic [CNT_W-1:0]  event_count
);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    QUALIFY = 2'd1,
    REPORT  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] SAT_C      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THRESH_M1_C = CNT_W'(THRESHOLD - 1);

  state_t           state_r;
  state_t           state_next_s;
  logic [CNT_W-1:0] qcnt_r;
  logic [CNT_W-1:0] qcnt_next_s;
  logic             enter_report_s;
  logic             report_valid_r;
  logic             deadlock_active_r;
  logic [7:0]       report_axis_r;
  logic [17:0]      report_idle_r;
  logic [10:0]      report_chan_r;
  logic [7:0]       report_seq_r;
  logic [7:0]       seq_cnt_r;
  logic [CNT_W-1:0] event_count_r;

  // Next-state and qualify-counter logic
  always_comb begin
    state_next_s   = state_r;
    qcnt_next_s    = qcnt_r;
    enter_report_s = 1'b0;
    case (state_r)
      ARMED: begin
        if (block) begin
          if (THRESHOLD == 1) begin
            state_next_s   = REPORT;
            enter_report_s = 1'b1;
          end else begin
            state_next_s = QUALIFY;
            qcnt_next_s  = ONE_C;
          end
        end else begin
          state_next_s = ARMED;
        end
      end
      QUALIFY: begin
        if (!block) begin
          state_next_s = ARMED;
          qcnt_next_s  = ZERO_C;
        end else if (qcnt_r == THRESH_M1_C) begin
          state_next_s   = REPORT;
          qcnt_next_s    = ZERO_C;
          enter_report_s = 1'b1;
        end else begin
          qcnt_next_s = qcnt_r + ONE_C;
        end
      end
      REPORT: begin
        // report_valid is always high here, so ready alone completes the transfer
        if (report_ready) begin
          state_next_s = block ? HOLD : ARMED;
        end else begin
          state_next_s = REPORT;
        end
      end
      HOLD: begin
        if (!block) begin
          state_next_s = ARMED;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: begin
        state_next_s = ARMED;
        qcnt_next_s  = ZERO_C;
      end
    endcase
  end

  // State, qualify counter and status flags
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r           <= ARMED;
      qcnt_r            <= ZERO_C;
      report_valid_r    <= 1'b0;
      deadlock_active_r <= 1'b0;
    end else begin
      state_r           <= state_next_s;
      qcnt_r            <= qcnt_next_s;
      report_valid_r    <= (state_next_s == REPORT);
      deadlock_active_r <= (state_next_s == REPORT) || (state_next_s == HOLD);
    end
  end

  // Snapshot capture, sequence numbering and saturating event count
  always_ff @(posedge clock) begin
    if (reset) begin
      report_axis_r <= 8'd0;
      report_idle_r <= 18'd0;
      report_chan_r <= 11'd0;
      report_seq_r  <= 8'd0;
      seq_cnt_r     <= 8'd0;
      event_count_r <= ZERO_C;
    end else if (enter_report_s) begin
      report_axis_r <= axis_block_sigs;
      report_idle_r <= inst_idle_sigs;
      report_chan_r <= inst_block_sigs;
      report_seq_r  <= seq_cnt_r;
      seq_cnt_r     <= seq_cnt_r + 8'd1;
      event_count_r <= (event_count_r == SAT_C) ? event_count_r : event_count_r + ONE_C;
    end else begin
      report_axis_r <= report_axis_r;
      report_idle_r <= report_idle_r;
      report_chan_r <= report_chan_r;
      report_seq_r  <= report_seq_r;
      seq_cnt_r     <= seq_cnt_r;
      event_count_r <= event_count_r;
    end
  end

  assign report_valid    = report_valid_r;
  assign deadlock_active = deadlock_active_r;
  assign report_axis     = report_axis_r;
  assign report_idle     = report_idle_r;
  assign report_chan     = report_chan_r;
  assign report_seq      = report_seq_r;
  assign event_count     = event_count_r;

endmodule
